// File: rtl/vcc_pkg.sv
// vcc_pkg: shared state encoding, default widths and entry layout for value_change_capture
package vcc_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int TS_W_DEF   = 16;
  localparam int DROP_W_DEF = 8;
  typedef enum logic {S_PRIME = 1'b0, S_TRACK = 1'b1} state_t;
  typedef struct packed {
    logic                  first;
    logic [TS_W_DEF-1:0]   ts;
    logic [DATA_W_DEF-1:0] value;
  } entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with occupancy count, async active-low reset
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     valid,
  output logic                     full,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_push, do_pop;
  assign valid = lvl_q != '0;
  assign full  = lvl_q == LW'(DEPTH);
  assign level = lvl_q;
  assign dout  = valid ? mem_q[rd_q] : '0;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  always_comb begin
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    lvl_d   = lvl_q + LW'(do_push) - LW'(do_pop);
  end
  // Pointer and occupancy state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end
  // Storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/value_change_capture.sv
// value_change_capture: logs timestamped changes of a monitored bus into a FIFO drained by valid/ready
module value_change_capture
  import vcc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_en,
  input  logic [DATA_W-1:0]         in_value,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_value,
  output logic [TS_W-1:0]           out_ts,
  output logic                      out_first,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [DROP_W-1:0]         dropped_cnt,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int EW = 1 + TS_W + DATA_W;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              capture, drop, full;
  logic [EW-1:0]     head;
  assign {out_first, out_ts, out_value} = head;
  assign overflow    = ovf_q;
  assign dropped_cnt = drop_q;
  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (capture),
    .din   ({state_q == S_PRIME, ts_q, in_value}),
    .pop   (out_ready),
    .valid (out_valid),
    .full  (full),
    .dout  (head),
    .level (level)
  );
  // Change detection, drop accounting and next-state; a drop in the same cycle as a clear wins
  always_comb begin
    capture = sample_en && (state_q == S_PRIME || in_value != prev_q);
    drop    = capture && full && !out_ready;
    state_d = sample_en ? S_TRACK : state_q;
    prev_d  = capture ? in_value : prev_q;
    ts_d    = ts_q + TS_W'(1);
    ovf_d   = drop ? 1'b1 : clear_overflow ? 1'b0 : ovf_q;
    drop_d  = drop ? (clear_overflow ? DROP_W'(1) : &drop_q ? drop_q : drop_q + DROP_W'(1))
                   : clear_overflow ? '0 : drop_q;
  end
  // Tracking FSM, timestamp counter and overflow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_PRIME;
      prev_q  <= '0;
      ts_q    <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      ts_q    <= ts_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_value_change_capture.sv
// tb_value_change_capture: directed scenario tests for value_change_capture
module tb_value_change_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_en = 1'b0;
  logic [31:0] in_value = '0;
  logic        out_ready = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        out_valid, out_first, overflow;
  logic [31:0] out_value;
  logic [15:0] out_ts;
  logic [7:0]  dropped_cnt;
  logic [2:0]  level;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ts = '0;
  logic [15:0] tt [6];
  value_change_capture dut (
    .clk            (clk),
    .reset          (reset),
    .sample_en      (sample_en),
    .in_value       (in_value),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_value      (out_value),
    .out_ts         (out_ts),
    .out_first      (out_first),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .dropped_cnt    (dropped_cnt),
    .level          (level)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
    ts = ts + 16'd1;
  endtask
  task automatic samp(input logic [31:0] v);
    sample_en = 1'b1;
    in_value  = v;
    step();
    sample_en = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d want 0", dropped_cnt); end
    checks++; if ({out_value, out_ts, out_first} !== 49'd0) begin errors++; $display("FAIL reset_head: got %h/%h/%b want 0", out_value, out_ts, out_first); end
    reset = 1'b1;
    ts = '0;
  endtask
  task automatic test_prime();
    repeat (3) step();
    samp(32'd0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL prime_valid: got %b want 1", out_valid); end
    checks++; if (out_value !== 32'd0) begin errors++; $display("FAIL prime_value: got %h want 0", out_value); end
    checks++; if (out_ts !== 16'd3) begin errors++; $display("FAIL prime_ts: got %0d want 3", out_ts); end
    checks++; if (out_first !== 1'b1) begin errors++; $display("FAIL prime_first: got %b want 1", out_first); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL prime_level: got %0d want 1", level); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prime_pop: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask
  task automatic test_filter();
    logic [31:0] vals [5];
    logic        cap  [5];
    logic [15:0] t;
    vals = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd5};
    cap  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      t = ts;
      samp(vals[i]);
      checks++; if (out_valid !== cap[i]) begin errors++; $display("FAIL filter_valid[%0d]: got %b want %b", i, out_valid, cap[i]); end
      if (cap[i]) begin
        checks++; if (out_value !== vals[i] || out_ts !== t || out_first !== 1'b0) begin errors++; $display("FAIL filter_entry[%0d]: got %0d/%0d/%b want %0d/%0d/0", i, out_value, out_ts, out_first, vals[i], t); end
      end
      checks++; if (level > 3'd1) begin errors++; $display("FAIL filter_level[%0d]: got %0d want <=1", i, level); end
    end
    step();
    out_ready = 1'b0;
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 6; i++) begin
      tt[i] = ts;
      samp(32'd10 + 32'(i));
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (dropped_cnt !== 8'd2) begin errors++; $display("FAIL ovf_dropped: got %0d want 2", dropped_cnt); end
    checks++; if (out_value !== 32'd10 || out_ts !== tt[0]) begin errors++; $display("FAIL ovf_head: got %0d/%0d want 10/%0d", out_value, out_ts, tt[0]); end
    step();
    checks++; if (out_value !== 32'd10 || out_ts !== tt[0] || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_stable: got %0d/%0d want 10/%0d", out_value, out_ts, tt[0]); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_value !== 32'd10 + 32'(i) || out_ts !== tt[i]) begin errors++; $display("FAIL ovf_drain[%0d]: got %0d/%0d want %0d/%0d", i, out_value, out_ts, 10 + i, tt[i]); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask
  task automatic test_back_to_back();
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0 || dropped_cnt !== 8'd0) begin errors++; $display("FAIL clear: got %b/%0d want 0/0", overflow, dropped_cnt); end
    for (int i = 0; i < 4; i++) samp(32'd20 + 32'(i));
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d want 4", level); end
    out_ready = 1'b1;
    samp(32'd24);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d want 4", level); end
    checks++; if (overflow !== 1'b0 || dropped_cnt !== 8'd0) begin errors++; $display("FAIL b2b_nodrop: got %b/%0d want 0/0", overflow, dropped_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_value !== 32'd21 + 32'(i)) begin errors++; $display("FAIL b2b_drain[%0d]: got %0d want %0d", i, out_value, 21 + i); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask
  task automatic test_clear_collision();
    for (int i = 0; i < 7; i++) samp(32'd30 + 32'(i));
    checks++; if (overflow !== 1'b1 || dropped_cnt !== 8'd3) begin errors++; $display("FAIL coll_pre: got %b/%0d want 1/3", overflow, dropped_cnt); end
    clear_overflow = 1'b1;
    samp(32'd37);
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b1 || dropped_cnt !== 8'd1) begin errors++; $display("FAIL coll_win: got %b/%0d want 1/1", overflow, dropped_cnt); end
    for (int i = 0; i < 300; i++) samp(32'd38 + 32'(i & 1));
    checks++; if (dropped_cnt !== 8'd255) begin errors++; $display("FAIL sat: got %0d want 255", dropped_cnt); end
    checks++; if (level !== 3'd4 || out_value !== 32'd30) begin errors++; $display("FAIL sat_head: got %0d/%0d want 4/30", level, out_value); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_value !== 32'd30 + 32'(i)) begin errors++; $display("FAIL coll_drain[%0d]: got %0d want %0d", i, out_value, 30 + i); end
      step();
    end
    out_ready = 1'b0;
    samp(32'd39);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_prev: got %b want 0", out_valid); end
    samp(32'd40);
    checks++; if (out_valid !== 1'b1 || out_value !== 32'd40) begin errors++; $display("FAIL drop_next: got %b/%0d want 1/40", out_valid, out_value); end
    out_ready = 1'b1;
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    out_ready = 1'b0;
  endtask
  task automatic test_reset_midrun();
    samp(32'd50);
    samp(32'd51);
    samp(32'd52);
    out_ready = 1'b1;
    step();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL async_reset: got %b/%0d want 0/0", out_valid, level); end
    checks++; if (out_value !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL async_reset_out: got %0d/%b want 0/0", out_value, overflow); end
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    ts = '0;
    samp(32'd0);
    checks++; if (out_valid !== 1'b1 || out_first !== 1'b1 || out_ts !== 16'd0) begin errors++; $display("FAIL reprime: got %b/%b/%0d want 1/1/0", out_valid, out_first, out_ts); end
    out_ready = 1'b1;
    step();
  endtask
  task automatic test_wrap();
    while (ts != 16'hFFFF) step();
    samp(32'd1);
    checks++; if (out_value !== 32'd1 || out_ts !== 16'hFFFF || out_first !== 1'b0) begin errors++; $display("FAIL wrap_last: got %0d/%h/%b want 1/ffff/0", out_value, out_ts, out_first); end
    samp(32'd2);
    checks++; if (out_value !== 32'd2 || out_ts !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %0d/%h want 2/0000", out_value, out_ts); end
    out_ready = 1'b0;
  endtask
  initial begin
    test_reset();
    test_prime();
    test_filter();
    test_overflow();
    test_back_to_back();
    test_clear_collision();
    test_reset_midrun();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
